// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_loader
//  Description : Byte-stream instruction loader. Receives a 16-bit little-
//                endian word count N followed by N little-endian 4-byte
//                instruction words and writes each word into instruction
//                memory at consecutive word addresses. The processor is held
//                in reset for the duration of the session.
//                Optional feature macro: INSTR_LOADER_CHECKSUM_EN
//                  When defined, a 4-byte little-endian trailer is accepted
//                  after the payload and compared with the mod-2^32 sum of
//                  all written words.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_loader #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           word_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN_LO  = 3'd1;
    localparam logic [2:0] S_LEN_HI  = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_CHECK   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
    localparam logic [2:0] S_ERR     = 3'd7;

    // Memory capacity in words; wide enough that the shift never overflows.
    localparam logic [32:0] C_CAPACITY = 33'd1 << ADDR_WIDTH;

    logic [2:0]  state_q,      state_d;
    logic [15:0] len_q,        len_d;
    logic [15:0] word_count_q, word_count_d;
    logic [1:0]  byte_idx_q,   byte_idx_d;
    logic [31:0] word_q,       word_d;

    logic        xfer;
    logic [15:0] count_inc;
    logic [15:0] len_full;

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
    logic [31:0] trailer;
`endif

    // Handshake and helper values shared by the next-state logic.
    assign xfer      = byte_valid & byte_ready;
    assign count_inc = word_count_q + 16'd1;
    assign len_full  = {byte_in, len_q[7:0]};

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Complete trailer as seen on the cycle its last byte is accepted.
    assign trailer = {byte_in, word_q[23:0]};
`endif

    // Next-state and datapath update for the load session.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_count_d = word_count_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d      = S_LEN_LO;
                    len_d        = 16'd0;
                    word_count_d = 16'd0;
                    byte_idx_d   = 2'd0;
                    word_d       = 32'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    sum_d        = 32'd0;
`endif
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = byte_in;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = byte_in;
                    // A count of exactly the capacity is legal; one more is not.
                    if ({17'd0, len_full} > C_CAPACITY) begin
                        state_d = S_ERR;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    word_d[{byte_idx_q, 3'b000} +: 8] = byte_in;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // Address for this write is the count before incrementing.
                word_count_d = count_inc;
`ifdef INSTR_LOADER_CHECKSUM_EN
                sum_d        = sum_q + word_q;
`endif
                if (count_inc == len_q) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_PAYLOAD;
                end
            end
            S_CHECK: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                // Trailer bytes reuse the word assembly register and index.
                if (xfer) begin
                    word_d[{byte_idx_q, 3'b000} +: 8] = byte_in;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = (trailer == sum_q) ? S_DONE : S_ERR;
                    end
                end
`else
                state_d = S_DONE;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            len_q        <= 16'd0;
            word_count_q <= 16'd0;
            byte_idx_q   <= 2'd0;
            word_q       <= 32'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum_q        <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_count_q <= word_count_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    // Outputs are decoded directly from the registered state and datapath.
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
    assign cpu_hold   = busy;
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign mem_we     = (state_q == S_WRITE);
    assign mem_addr   = ADDR_WIDTH'(word_count_q);
    assign mem_wdata  = WIDTH'(word_q);
    assign word_count = word_count_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    assign byte_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_PAYLOAD) || (state_q == S_CHECK);
`else
    assign byte_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_PAYLOAD);
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_loader
//  Description : Self-checking bench for instr_loader. Load sessions are
//                described as records (byte stream, pacing, expected writes
//                and final status) and replayed in a loop; reset and write
//                timing corner cases are hand-sequenced.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    instr_loader #(
        .WIDTH      (32),
        .ADDR_WIDTH (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int off;
        int nbytes;
        bit gap;
        int mid_start;
        int exp_off;
        int exp_n;
        bit exp_done;
        bit exp_err;
        int exp_wc;
    } vec_t;

    logic [7:0]  pool[$];
    logic [31:0] exp_pool[$];
    vec_t        vecs[$];
    int          cur_off;
    int          cur_exp_off;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          rdy_viol = 0;

    int n_checks = 0;
    int n_pass   = 0;

    // Capture every memory write mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(32'(mem_addr));
            wr_data.push_back(mem_wdata);
            if (byte_ready) rdy_viol <= rdy_viol + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic open_vec();
        cur_off     = pool.size();
        cur_exp_off = exp_pool.size();
    endtask

    task automatic close_vec(input bit gap, input int mid, input bit edone, input bit eerr, input int ewc);
        vec_t v;
        v.off       = cur_off;
        v.nbytes    = pool.size() - cur_off;
        v.gap       = gap;
        v.mid_start = mid;
        v.exp_off   = cur_exp_off;
        v.exp_n     = exp_pool.size() - cur_exp_off;
        v.exp_done  = edone;
        v.exp_err   = eerr;
        v.exp_wc    = ewc;
        vecs.push_back(v);
    endtask

    // Called at posedge+1; returns at posedge+1 after the last handshake.
    task automatic send_bytes(input int off, input int n, input bit gap, input int mid);
        int  i      = 0;
        int  cyc    = 0;
        int  budget = 3 * n + 20;
        bit  toggle = 1'b0;
        bit  take;
        while (i < n && cyc < budget) begin
            start = (i == mid);
            if (gap && toggle) begin
                byte_valid = 1'b0;
            end else begin
                byte_valid = 1'b1;
                byte_in    = pool[off + i];
            end
            take   = byte_valid && byte_ready;
            toggle = !toggle;
            @(posedge clk);
            #1;
            if (take) i++;
            cyc++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        if (i < n) check("send_timeout", 64'(i), 64'(n));
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        int   base_w;
        int   base_v;
        int   cyc;
        v      = vecs[k];
        base_w = wr_addr.size();
        base_v = rdy_viol;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        check($sformatf("v%0d start_clear", k), {60'd0, done, error, busy, cpu_hold}, 64'h3);
        check($sformatf("v%0d start_count", k), 64'(word_count), 64'd0);
        send_bytes(v.off, v.nbytes, v.gap, v.mid_start);
        cyc = 0;
        while (!(done || error) && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check($sformatf("v%0d done", k), 64'(done), 64'(v.exp_done));
        check($sformatf("v%0d error", k), 64'(error), 64'(v.exp_err));
        check($sformatf("v%0d word_count", k), 64'(word_count), 64'(v.exp_wc));
        check($sformatf("v%0d idle_flags", k), {61'd0, busy, cpu_hold, byte_ready}, 64'd0);
        check($sformatf("v%0d ready_in_write", k), 64'(rdy_viol - base_v), 64'd0);
        check($sformatf("v%0d writes", k), 64'(wr_addr.size() - base_w), 64'(v.exp_n));
        if (wr_addr.size() - base_w == v.exp_n) begin
            for (int j = 0; j < v.exp_n; j++) begin
                check($sformatf("v%0d addr[%0d]", k, j), 64'(wr_addr[base_w + j]), 64'(j));
                check($sformatf("v%0d data[%0d]", k, j), 64'(wr_data[base_w + j]), 64'(exp_pool[v.exp_off + j]));
            end
        end
    endtask

    initial begin
        int base_w;
        rst        = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;

        // ---------------- session table ----------------
        // 0: two-word load, valid held high
        open_vec();
        pool = {pool, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
`ifdef INSTR_LOADER_CHECKSUM_EN
        pool = {pool, 8'hA6, 8'h01, 8'hF0, 8'h00};
`endif
        exp_pool = {exp_pool, 32'h00500093, 32'h00A00113};
        close_vec(1'b0, -1, 1'b1, 1'b0, 2);
        // 1: same stream, valid low every other cycle
        open_vec();
        for (int i = 0; i < vecs[0].nbytes; i++) pool.push_back(pool[vecs[0].off + i]);
        exp_pool = {exp_pool, 32'h00500093, 32'h00A00113};
        close_vec(1'b1, -1, 1'b1, 1'b0, 2);
        // 2: length 1025 exceeds capacity
        open_vec();
        pool = {pool, 8'h01, 8'h04};
        close_vec(1'b0, -1, 1'b0, 1'b1, 0);
        // 3: zero-length load
        open_vec();
        pool = {pool, 8'h00, 8'h00};
`ifdef INSTR_LOADER_CHECKSUM_EN
        pool = {pool, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
        close_vec(1'b0, -1, 1'b1, 1'b0, 0);
        // 4: three words including all-ones and MSB-only patterns
        open_vec();
        pool = {pool, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                8'h00, 8'h00, 8'h00, 8'h80};
`ifdef INSTR_LOADER_CHECKSUM_EN
        pool = {pool, 8'h10, 8'h22, 8'h33, 8'hC4};
`endif
        exp_pool = {exp_pool, 32'h44332211, 32'hFFFFFFFF, 32'h80000000};
        close_vec(1'b1, -1, 1'b1, 1'b0, 3);
        // 5: start re-asserted mid-session must be ignored
        open_vec();
        for (int i = 0; i < vecs[0].nbytes; i++) pool.push_back(pool[vecs[0].off + i]);
        exp_pool = {exp_pool, 32'h00500093, 32'h00A00113};
        close_vec(1'b0, 4, 1'b1, 1'b0, 2);
        // 6: exactly full capacity (1024 words)
        open_vec();
        pool = {pool, 8'h00, 8'h04};
        for (int k = 0; k < 1024; k++) begin
            logic [31:0] w;
            w = 32'(k);
            pool = {pool, w[7:0], w[15:8], w[23:16], w[31:24]};
            exp_pool.push_back(w);
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        pool = {pool, 8'h00, 8'hFE, 8'h07, 8'h00};
`endif
        close_vec(1'b0, -1, 1'b1, 1'b0, 1024);
`ifdef INSTR_LOADER_CHECKSUM_EN
        // 7: checksum mismatch
        open_vec();
        for (int i = 0; i < 10; i++) pool.push_back(pool[vecs[0].off + i]);
        pool = {pool, 8'hA7, 8'h01, 8'hF0, 8'h00};
        exp_pool = {exp_pool, 32'h00500093, 32'h00A00113};
        close_vec(1'b0, -1, 1'b0, 1'b1, 2);
`endif

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst byte_ready", 64'(byte_ready), 64'd0);
        check("rst mem_we", 64'(mem_we), 64'd0);
        check("rst mem_addr", 64'(mem_addr), 64'd0);
        check("rst mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst flags", {60'd0, cpu_hold, busy, done, error}, 64'd0);
        check("rst word_count", 64'(word_count), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("idle byte_ready", 64'(byte_ready), 64'd0);

        // ---------------- write timing, then reset mid-word ----------------
        base_w = wr_addr.size();
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        send_bytes(vecs[0].off, 6, 1'b0, -1);
        check("t0 mem_we", 64'(mem_we), 64'd1);
        check("t0 byte_ready", 64'(byte_ready), 64'd0);
        check("t0 mem_addr", 64'(mem_addr), 64'd0);
        check("t0 mem_wdata", 64'(mem_wdata), 64'h00500093);
        @(posedge clk);
        #1;
        check("t1 mem_we", 64'(mem_we), 64'd0);
        check("t1 byte_ready", 64'(byte_ready), 64'd1);
        check("t1 word_count", 64'(word_count), 64'd1);
        send_bytes(vecs[0].off + 6, 2, 1'b0, -1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("abort byte_ready", 64'(byte_ready), 64'd0);
        check("abort mem_we", 64'(mem_we), 64'd0);
        check("abort mem_addr", 64'(mem_addr), 64'd0);
        check("abort mem_wdata", 64'(mem_wdata), 64'd0);
        check("abort flags", {60'd0, cpu_hold, busy, done, error}, 64'd0);
        check("abort word_count", 64'(word_count), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        check("abort writes", 64'(wr_addr.size() - base_w), 64'd1);

        // ---------------- table-driven sessions ----------------
        for (int k = 0; k < vecs.size(); k++) begin
            run_vec(k);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter: WIDTH, 32, instruction word width in bits.
REQ-002 Parameter: ADDR_WIDTH, 10, instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-low.
REQ-005 Port: start  input  1  begin a load session.
REQ-006 Port: byte_in  input  8  stream byte.
REQ-007 Port: byte_valid  input  1  byte_in valid.
REQ-008 Port: byte_ready  output  1  loader accepts byte_in this cycle.
REQ-009 Port: mem_we  output  1  instruction-memory write strobe, one-cycle pulse per word.
REQ-010 Port: mem_addr  output  ADDR_WIDTH  word address of the write.
REQ-011 Port: mem_wdata  output  WIDTH  assembled instruction word.
REQ-012 Port: cpu_hold  output  1  high holds the processor in reset while loading.
REQ-013 Port: busy  output  1  session in progress.
REQ-014 Port: done  output  1  load completed successfully; sticky until next start or reset.
REQ-015 Port: error  output  1  load aborted; sticky until next start or reset.
REQ-016 Port: word_count  output  16  words written this session.

Function
REQ-017 A byte SHALL transfer only on a cycle where byte_valid and byte_ready are both high.
REQ-018 FSM states SHALL be IDLE, LEN_LO, LEN_HI, PAYLOAD, WRITE, CHECK, DONE, ERR.
REQ-019 IDLE/DONE/ERR SHALL go to LEN_LO on start, clearing word_count, done, error, and the byte index.
REQ-020 start while busy SHALL be ignored.
REQ-021 LEN_LO, then LEN_HI, SHALL capture a 16-bit little-endian word count N.
REQ-022 After LEN_HI: N > 2^ADDR_WIDTH -> ERR; N = 0 -> CHECK; otherwise -> PAYLOAD.
REQ-023 PAYLOAD SHALL assemble 4 bytes little-endian (first byte = bits 7:0) and go to WRITE after the 4th byte.
REQ-024 WRITE SHALL last exactly one cycle with mem_we=1, mem_addr=word_count[ADDR_WIDTH-1:0], mem_wdata=assembled word, byte_ready=0.
REQ-025 WRITE SHALL increment word_count, then go to CHECK if the new count equals N, else to PAYLOAD.
REQ-026 Payload throughput SHALL be at most 1 word per 5 cycles; mem_we is one cycle after the 4th byte handshake.
REQ-027 byte_ready SHALL be high only in LEN_LO, LEN_HI and PAYLOAD, plus CHECK when REQ-034 applies.
REQ-028 CHECK without checksum SHALL go to DONE on the next cycle.
REQ-029 busy and cpu_hold SHALL be high in every state except IDLE, DONE and ERR.
REQ-030 done SHALL be high only in DONE; error SHALL be high only in ERR.
REQ-031 mem_we SHALL be low in every state other than WRITE.

Reset
REQ-032 On rising clk with rst=0 the block SHALL enter IDLE with byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, busy=0, done=0, error=0, word_count=0, N=0.
REQ-033 Reset mid-session SHALL abort immediately, with no further mem_we pulse; memory contents already written are undefined to the processor.

Configuration
REQ-034 With INSTR_LOADER_CHECKSUM_EN defined, CHECK SHALL accept 4 further little-endian bytes and compare them with the mod-2^32 sum of all written words: match -> DONE, mismatch -> ERR.
REQ-035 With INSTR_LOADER_CHECKSUM_EN defined and N = 0, the expected checksum SHALL be 0x00000000.
REQ-036 Without INSTR_LOADER_CHECKSUM_EN, no checksum logic SHALL exist and CHECK SHALL behave per REQ-028.

Verification
REQ-037 start, then bytes 02 00 | 93 00 50 00 | 13 01 A0 00 with byte_valid held high -> writes addr0=0x00500093 and addr1=0x00A00113; done=1; word_count=2.
REQ-038 Same stream with byte_valid low on alternate cycles -> identical writes; byte_ready=0 in each WRITE cycle; no byte lost or duplicated.
REQ-039 Length bytes 01 04 (N=1025, ADDR_WIDTH=10) -> error=1, mem_we never asserted, cpu_hold=0.
REQ-040 rst=0 after the 2nd payload byte of word 1 -> next cycle: IDLE, all outputs 0; a following complete load succeeds.
REQ-041 With INSTR_LOADER_CHECKSUM_EN: stream per REQ-037 plus trailer A6 01 F0 00 -> done=1; trailer A7 01 F0 00 -> error=1.
REQ-042 Length 00 00 -> done=1 with word_count=0 and no mem_we, without the macro; with the macro, after trailer 00 00 00 00.
